// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared glyph codes and FSM state type for the seven-segment
//             scan decoder. Codes are active-low segments {g,f,e,d,c,b,a}.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index of an entry is the nibble it decodes to
  localparam logic [6:0] SEG_GLYPH [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_scan_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_decoder_if
//  Purpose  : Bundles the multiplexed display bus and the decoded results.
//             master = display driver / consumer side, slave = decoder.
//  Revision : 1.0  initial release
// ============================================================================
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 8
);

  logic [7:0]              seg_in;
  logic [NUM_DIGITS-1:0]   an_in;
  logic                    clr;
  logic [4*NUM_DIGITS-1:0] digits_o;
  logic [NUM_DIGITS-1:0]   valid_o;
  logic [NUM_DIGITS-1:0]   dp_o;
  logic                    frame_done_o;
  logic                    err_o;

  modport master (
    output seg_in, an_in, clr,
    input  digits_o, valid_o, dp_o, frame_done_o, err_o
  );

  modport slave (
    input  seg_in, an_in, clr,
    output digits_o, valid_o, dp_o, frame_done_o, err_o
  );

endinterface
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Purpose  : Combinational lookup of a 7-bit active-low segment code back to
//             its hex nibble; also flags the all-off blank pattern.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic       blank,
  output logic [3:0] nibble
);

  // Scan the glyph table; codes are unique so at most one entry matches
  always_comb begin
    hit    = 1'b0;
    nibble = 4'h0;
    blank  = (seg == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_GLYPH[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_decoder
//  Purpose  : Watches a multiplexed active-low seven-segment bus, waits for
//             each digit pattern to be stable, decodes and stores it per
//             digit position, and pulses when a full frame was captured.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int STABLE_CYC = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  seg7_scan_decoder_if.slave bus
);

  localparam int             CW   = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
  localparam int             SW   = NUM_DIGITS + 8;
  localparam logic [CW-1:0]  CMAX = CW'(STABLE_CYC - 1);

  logic [SW-1:0]           r_samp;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_nxt;
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic                    r_frame;
  logic                    r_err;

  logic                    w_same;
  logic                    w_in_none;
  logic                    w_commit;
  logic [NUM_DIGITS-1:0]   w_an_low;
  logic                    w_one;
  logic [NUM_DIGITS-1:0]   w_wr;
  logic [NUM_DIGITS-1:0]   w_seen_nxt;
  logic                    w_frame;
  logic                    w_err_set;
  logic                    w_hit;
  logic                    w_blank;
  logic [3:0]              w_nibble;
  logic [4*NUM_DIGITS-1:0] w_digits;
  logic [NUM_DIGITS-1:0]   w_valid;
  logic [NUM_DIGITS-1:0]   w_dp;

  assign w_same    = ({bus.an_in, bus.seg_in} == r_samp);
  assign w_in_none = &bus.an_in;

  // Commits only happen when the new sample equals r_samp, so decoding the
  // registered sample is the same as decoding the live inputs.
  assign w_an_low  = ~r_samp[SW-1:8];
  assign w_one     = $onehot(w_an_low);
  assign w_wr      = (w_commit && w_one) ? w_an_low : '0;
  assign w_seen_nxt = r_seen | w_wr;
  assign w_frame   = (|w_wr) && (&w_seen_nxt);
  assign w_err_set = w_commit && (!w_one || (!w_hit && !w_blank));

  seg7_decode u_decode (
    .seg    (r_samp[6:0]),
    .hit    (w_hit),
    .blank  (w_blank),
    .nibble (w_nibble)
  );

  // Next-state, stable counter and commit decision; clr overrides everything
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    if (!w_same) begin
      w_cnt_nxt   = '0;
      w_state_nxt = w_in_none ? IDLE : SETTLE;
    end else begin
      if (r_cnt != CMAX) w_cnt_nxt = r_cnt + CW'(1);
      case (r_state)
        IDLE: begin
          if (!w_in_none) begin
            w_state_nxt = SETTLE;
            w_cnt_nxt   = '0;
          end
        end
        SETTLE: begin
          if (w_in_none) begin
            w_state_nxt = IDLE;
          end else if (r_cnt == CMAX) begin
            w_commit    = 1'b1;
            w_state_nxt = HELD;
          end
        end
        HELD:    w_state_nxt = HELD;
        default: w_state_nxt = IDLE;
      endcase
    end
    if (bus.clr) begin
      w_cnt_nxt   = '0;
      w_state_nxt = SETTLE;
      w_commit    = 1'b0;
    end
  end

  // Sampler, FSM state, frame tracking and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samp  <= '0;
      r_cnt   <= '0;
      r_state <= IDLE;
      r_seen  <= '0;
      r_frame <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_samp  <= {bus.an_in, bus.seg_in};
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      if (bus.clr) begin
        r_seen  <= '0;
        r_frame <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        r_seen  <= w_frame ? '0 : w_seen_nxt;
        r_frame <= w_frame;
        if (w_err_set) r_err <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [3:0] r_nib;
    logic       r_val;
    logic       r_dp;

    // Per-digit capture; a blank or illegal glyph keeps the old nibble
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_nib <= 4'h0;
        r_val <= 1'b0;
        r_dp  <= 1'b0;
      end else if (bus.clr) begin
        r_nib <= 4'h0;
        r_val <= 1'b0;
        r_dp  <= 1'b0;
      end else if (w_wr[i]) begin
        if (w_hit) r_nib <= w_nibble;
        r_val <= w_hit;
        r_dp  <= ~r_samp[7];
      end
    end

    assign w_digits[4*i +: 4] = r_nib;
    assign w_valid[i]         = r_val;
    assign w_dp[i]            = r_dp;
  end

  assign bus.digits_o     = w_digits;
  assign bus.valid_o      = w_valid;
  assign bus.dp_o         = w_dp;
  assign bus.frame_done_o = r_frame;
  assign bus.err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_decoder
//  Purpose  : Directed self-checking bench for seg7_scan_decoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_decoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   n_pulse = 0;
  int   base;

  // Full 8-bit bus values (dp off) for glyphs 0..8
  localparam logic [7:0] GLYPH [9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80
  };

  always #5 clk = ~clk;

  seg7_scan_decoder_if #(.NUM_DIGITS(8)) bus ();

  seg7_scan_decoder #(.NUM_DIGITS(8), .STABLE_CYC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Count frame pulses; each registered pulse spans exactly one negedge
  always @(negedge clk) if (bus.frame_done_o === 1'b1) n_pulse++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] an, input logic [7:0] seg);
    bus.an_in  = an;
    bus.seg_in = seg;
  endtask

  task automatic sweep(input string tag);
    for (int d = 0; d < 7; d++) begin
      drive(~(8'(1) << d), GLYPH[d+1]);
      step(6);
    end
    drive(8'h7F, GLYPH[8]);
    step(5);
    chk({tag, "_frame_on"}, 32'(bus.frame_done_o), 32'h1);
    step(1);
    chk({tag, "_frame_off"}, 32'(bus.frame_done_o), 32'h0);
  endtask

  initial begin
    bus.clr = 1'b0;
    // 1. Reset with random inputs
    for (int k = 0; k < 3; k++) begin
      drive(8'($urandom), 8'($urandom));
      step(1);
    end
    chk("rst_digits", bus.digits_o, 32'h0);
    chk("rst_valid", 32'(bus.valid_o), 32'h0);
    chk("rst_dp", 32'(bus.dp_o), 32'h0);
    chk("rst_frame", 32'(bus.frame_done_o), 32'h0);
    chk("rst_err", 32'(bus.err_o), 32'h0);
    drive(8'hFF, 8'hFF);
    rst_n = 1'b1;
    step(6);
    chk("idle_digits", bus.digits_o, 32'h0);
    chk("idle_valid", 32'(bus.valid_o), 32'h0);
    chk("idle_err", 32'(bus.err_o), 32'h0);

    // 2. Two single digits, with latency boundary
    drive(8'hFE, 8'hC0);
    step(4);
    chk("lat_not_yet", 32'(bus.valid_o), 32'h0);
    step(1);
    chk("d0_digits", bus.digits_o, 32'h0);
    chk("d0_valid", 32'(bus.valid_o), 32'h01);
    chk("d0_dp", 32'(bus.dp_o), 32'h00);
    drive(8'hFD, 8'h0E);
    step(5);
    chk("d1_digits", bus.digits_o, 32'h0000_00F0);
    chk("d1_valid", 32'(bus.valid_o), 32'h03);
    chk("d1_dp", 32'(bus.dp_o), 32'h02);

    // 3. Full sweeps
    drive(8'hFF, 8'hFF);
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    chk("pre_sweep_clr", bus.digits_o, 32'h0);
    sweep("sw1");
    chk("sw1_digits", bus.digits_o, 32'h8765_4321);
    chk("sw1_valid", 32'(bus.valid_o), 32'hFF);
    chk("sw1_dp", 32'(bus.dp_o), 32'h00);
    chk("sw1_pulses", 32'(n_pulse), 32'd1);
    sweep("sw2");
    chk("sw2_pulses", 32'(n_pulse), 32'd2);

    // 4. Glitch shorter than the stability window
    drive(8'hFE, GLYPH[2]);
    step(3);
    drive(8'hFF, 8'hFF);
    step(6);
    chk("glitch_digits", bus.digits_o, 32'h8765_4321);
    chk("glitch_valid", 32'(bus.valid_o), 32'hFF);

    // 5. Blank, illegal, multi-anode
    drive(8'hFB, 8'hFF);
    step(6);
    chk("blank_valid", 32'(bus.valid_o), 32'hFB);
    chk("blank_err", 32'(bus.err_o), 32'h0);
    chk("blank_digits", bus.digits_o, 32'h8765_4321);
    drive(8'hF7, 8'hD5);
    step(6);
    chk("illegal_err", 32'(bus.err_o), 32'h1);
    chk("illegal_valid", 32'(bus.valid_o), 32'hF3);
    drive(8'hEF, GLYPH[0]);
    step(6);
    chk("sticky_err", 32'(bus.err_o), 32'h1);
    chk("sticky_digits", bus.digits_o, 32'h8760_4321);
    drive(8'hFF, 8'hFF);
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    chk("clr_digits", bus.digits_o, 32'h0);
    chk("clr_valid", 32'(bus.valid_o), 32'h0);
    chk("clr_dp", 32'(bus.dp_o), 32'h0);
    chk("clr_err", 32'(bus.err_o), 32'h0);
    drive(8'hFC, GLYPH[0]);
    step(6);
    chk("multi_err", 32'(bus.err_o), 32'h1);
    chk("multi_digits", bus.digits_o, 32'h0);
    chk("multi_valid", 32'(bus.valid_o), 32'h0);
    drive(8'hFF, 8'hFF);
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    chk("multi_clr_err", 32'(bus.err_o), 32'h0);

    // 6a. Async reset in the middle of settling
    drive(8'hFE, 8'h00);
    step(6);
    chk("pre_rst_digits", bus.digits_o, 32'h8);
    chk("pre_rst_dp", 32'(bus.dp_o), 32'h01);
    drive(8'hFD, GLYPH[1]);
    step(2);
    rst_n = 1'b0;
    #2;
    chk("async_digits", bus.digits_o, 32'h0);
    chk("async_valid", 32'(bus.valid_o), 32'h0);
    chk("async_dp", 32'(bus.dp_o), 32'h0);
    drive(8'hFF, 8'hFF);
    rst_n = 1'b1;
    step(2);

    // 6b. clr on the edge of the frame-completing commit
    for (int d = 0; d < 7; d++) begin
      drive(~(8'(1) << d), GLYPH[d+1]);
      step(6);
    end
    drive(8'h7F, GLYPH[8]);
    step(4);
    base = n_pulse;
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    chk("clrcommit_frame", 32'(bus.frame_done_o), 32'h0);
    chk("clrcommit_digits", bus.digits_o, 32'h0);
    step(5);
    chk("recommit_digits", bus.digits_o, 32'h8000_0000);
    chk("recommit_valid", 32'(bus.valid_o), 32'h80);
    chk("recommit_pulses", 32'(n_pulse), 32'(base));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
